// File: rtl/facto_master.sv
// Bus master that walks a list of 64-bit operands in memory, feeds each one
// to a memory-mapped factorial core, waits for its completion interrupt and
// writes the result back to a destination list.
module facto_master #(
    parameter logic [15:0] CORE_BASE = 16'h7000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] src_base,
    input  logic [15:0] dst_base,
    input  logic [7:0]  count,
    output logic        busy,
    output logic        done,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt
);

    localparam logic [15:0] OFS_START = 16'h0000;
    localparam logic [15:0] OFS_CLEAR = 16'h0008;
    localparam logic [15:0] OFS_DONE  = 16'h0010;
    localparam logic [15:0] OFS_IEN   = 16'h0018;
    localparam logic [15:0] OFS_OPND  = 16'h0020;
    localparam logic [15:0] OFS_RES   = 16'h0030;

    typedef enum logic [3:0] {
        IDLE, REQ, RD_OP, RD_OP_W, WR_OPND, WR_IEN, WR_STRT, WAIT_IRQ,
        RD_RES, RD_RES_W, WR_CLR1, WR_CLR0, WR_MEM, NEXT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, dst_q;
    logic [7:0]  cnt_q, idx_q;
    logic [63:0] data_q;
    logic        wr_cyc;
    logic        last_op;

    // Widened compare so idx+1 never wraps before being tested against count.
    assign last_op = ({1'b0, idx_q} + 9'd1) >= {1'b0, cnt_q};

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job configuration, operand index and the shared operand/result holder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= 16'h0000;
            dst_q  <= 16'h0000;
            cnt_q  <= 8'h00;
            idx_q  <= 8'h00;
            data_q <= 64'h0;
        end else begin
            if (state_q == IDLE && start) begin
                src_q <= src_base;
                dst_q <= dst_base;
                cnt_q <= count;
                idx_q <= 8'h00;
            end
            if (state_q == NEXT) begin
                idx_q <= idx_q + 8'd1;
            end
            // Read data is valid during the wait cycle and captured as it ends.
            if ((state_q == RD_OP_W || state_q == RD_RES_W) && m_grant) begin
                data_q <= m_din;
            end
        end
    end

    // Next-state logic: bus states advance only with grant, WAIT_IRQ only on interrupt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = (count == 8'd0) ? DONE : REQ;
            REQ:      if (m_grant) state_d = RD_OP;
            RD_OP:    if (m_grant) state_d = RD_OP_W;
            RD_OP_W:  if (m_grant) state_d = WR_OPND;
            WR_OPND:  if (m_grant) state_d = WR_IEN;
            WR_IEN:   if (m_grant) state_d = WR_STRT;
            WR_STRT:  if (m_grant) state_d = WAIT_IRQ;
            WAIT_IRQ: if (interrupt) state_d = RD_RES;
            RD_RES:   if (m_grant) state_d = RD_RES_W;
            RD_RES_W: if (m_grant) state_d = WR_CLR1;
            WR_CLR1:  if (m_grant) state_d = WR_CLR0;
            WR_CLR0:  if (m_grant) state_d = WR_MEM;
            WR_MEM:   if (m_grant) state_d = NEXT;
            NEXT:     state_d = last_op ? DONE : RD_OP;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Bus outputs are a pure function of state and held registers, so a stalled
    // grant leaves address and data untouched.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        m_req  = 1'b0;
        wr_cyc = 1'b0;
        m_addr = 16'h0000;
        m_dout = 64'h0;
        unique case (state_q)
            IDLE: ;
            REQ: begin
                busy  = 1'b1;
                m_req = 1'b1;
            end
            RD_OP, RD_OP_W: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                m_addr = src_q + {8'h00, idx_q};
            end
            WR_OPND: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                wr_cyc = 1'b1;
                m_addr = CORE_BASE + OFS_OPND;
                m_dout = data_q;
            end
            WR_IEN: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                wr_cyc = 1'b1;
                m_addr = CORE_BASE + OFS_IEN;
                m_dout = 64'd1;
            end
            WR_STRT: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                wr_cyc = 1'b1;
                m_addr = CORE_BASE + OFS_START;
                m_dout = 64'd1;
            end
            WAIT_IRQ: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                m_addr = CORE_BASE + OFS_DONE;
            end
            RD_RES, RD_RES_W: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                m_addr = CORE_BASE + OFS_RES;
            end
            WR_CLR1: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                wr_cyc = 1'b1;
                m_addr = CORE_BASE + OFS_CLEAR;
                m_dout = 64'd1;
            end
            WR_CLR0: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                wr_cyc = 1'b1;
                m_addr = CORE_BASE + OFS_CLEAR;
                m_dout = 64'd0;
            end
            WR_MEM: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                wr_cyc = 1'b1;
                m_addr = dst_q + {8'h00, idx_q};
                m_dout = data_q;
            end
            NEXT: begin
                busy  = 1'b1;
                m_req = !last_op;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // A write strobe is only ever presented while the arbiter grants the bus.
    assign m_wr = wr_cyc & m_grant;

endmodule

// File: tb/tb_facto_master.sv
// Scoreboard bench for facto_master with a memory and factorial-core model.
`timescale 1ns/1ps
module tb_facto_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_base, dst_base;
    logic [7:0]  count;
    logic        busy, done, m_req, m_grant, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout, m_din;
    logic        interrupt;

    logic        hold, irq_spur, irq_core, irq_seen, ien;
    logic [7:0]  cd;
    logic [63:0] core_opnd;
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [63:0] pre_data;
    logic [63:0] mem [0:65535];

    typedef struct {
        logic        is_done;
        logic [15:0] addr;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    facto_master #(.CORE_BASE(16'h7000)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .count(count),
        .busy(busy), .done(done), .m_req(m_req), .m_grant(m_grant),
        .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    assign m_grant   = m_req & ~hold;
    assign interrupt = irq_core | irq_spur;

    function automatic logic [63:0] fact(input logic [63:0] n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 2; k <= 20; k++)
            if (64'(k) <= n) r = r * 64'(k);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory, preload port and factorial core behind the bus.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (!reset_n) begin
            irq_core <= 1'b0;
            irq_seen <= 1'b0;
            cd       <= 8'd0;
            ien      <= 1'b0;
        end else begin
            if (cd != 8'd0) begin
                cd <= cd - 8'd1;
                if (cd == 8'd1) begin
                    irq_core <= 1'b1;
                    irq_seen <= 1'b1;
                end
            end
            if (m_req && m_grant && m_wr) begin
                case (m_addr)
                    16'h7020: core_opnd <= m_dout;
                    16'h7018: ien <= m_dout[0];
                    16'h7000: if (m_dout == 64'd1 && ien) begin cd <= 8'd8; irq_seen <= 1'b0; end
                    16'h7008: if (m_dout == 64'd1) irq_core <= 1'b0;
                    16'h7010, 16'h7030: ;
                    default:  mem[m_addr] <= m_dout;
                endcase
            end
        end
        m_din <= (m_addr == 16'h7030) ? fact(core_opnd) : mem[m_addr];
    end

    // Monitor: pops expected writes / done markers as the DUT presents them.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (m_wr) begin
                check("wr_grant", {63'd0, m_grant}, 64'd1);
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", m_addr, m_dout);
                end else begin
                    e = sbq.pop_front();
                    check("wr_kind", {63'd0, e.is_done}, 64'd0);
                    check("wr_addr", {48'd0, m_addr}, {48'd0, e.addr});
                    check("wr_data", m_dout, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_busy", {63'd0, busy}, 64'd0);
                check("done_mreq", {63'd0, m_req}, 64'd0);
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: done=1, none expected");
                end else begin
                    e = sbq.pop_front();
                    check("done_order", {63'd0, e.is_done}, 64'd1);
                end
            end
            if (m_req && m_grant && !m_wr && m_addr == 16'h7030)
                check("res_after_irq", {63'd0, irq_seen}, 64'd1);
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [63:0] d);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d;
        sbq.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.addr = 16'h0; e.data = 64'h0;
        sbq.push_back(e);
    endtask

    task automatic push_op(input logic [15:0] dst, input logic [63:0] op, input logic [63:0] res);
        push_wr(16'h7020, op);
        push_wr(16'h7018, 64'd1);
        push_wr(16'h7000, 64'd1);
        push_wr(16'h7008, 64'd1);
        push_wr(16'h7008, 64'd0);
        push_wr(dst, res);
    endtask

    task automatic preload(input logic [15:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] c);
        @(posedge clk); #1;
        src_base = s; dst_base = d; count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, {63'd0, (c != 8'd0)});
        check("done_after_start", {63'd0, done}, {63'd0, (c == 8'd0)});
    endtask

    task automatic wait_done(input int prev, input int budget);
        for (int k = 0; k < budget && done_cnt == prev; k++) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt == prev) begin
            n_bad++;
            $display("FAIL done_timeout: done count %0d, expected more than %0d", done_cnt, prev);
        end
        check("sb_drained", 64'(sbq.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_mreq"}, {63'd0, m_req}, 64'd0);
        check({tag, "_mwr"},  {63'd0, m_wr}, 64'd0);
        check({tag, "_addr"}, {48'd0, m_addr}, 64'd0);
        check({tag, "_dout"}, m_dout, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tab [0:3];
        int d0;
        logic [15:0] a0;
        tab[0] = 64'd1; tab[1] = 64'd2; tab[2] = 64'd6; tab[3] = 64'd24;
        reset_n = 1'b0; start = 1'b0; hold = 1'b0; irq_spur = 1'b0; pre_en = 1'b0;
        pre_addr = 16'h0; pre_data = 64'h0; core_opnd = 64'h0;
        src_base = 16'h0; dst_base = 16'h0; count = 8'h0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("por");
        reset_n = 1'b1;

        preload(16'h0070, 64'd5);
        preload(16'h0080, 64'd5);
        preload(16'h0081, 64'd10);
        preload(16'hFFFF, 64'd4);
        preload(16'h0000, 64'd6);
        preload(16'h0090, 64'd5);
        preload(16'h00A0, 64'd5);
        preload(16'h00B0, 64'd5);
        preload(16'h00B1, 64'hDEAD);
        preload(16'h00C0, 64'd5);
        for (int i = 0; i < 255; i++) preload(16'h0100 + 16'(i), 64'(i % 4 + 1));
        preload(16'h04FF, 64'hBEEF);

        // single operand
        push_op(16'h0071, 64'd5, 64'd120); push_done();
        d0 = done_cnt;
        start_job(16'h0070, 16'h0071, 8'd1);
        wait_done(d0, 200);
        check("single_mem", mem[16'h0071], 64'd120);
        repeat (4) @(posedge clk);
        check("single_one_done", 64'(done_cnt), 64'(d0 + 1));
        check_reset_outputs("idle");

        // two operands
        push_op(16'h00F0, 64'd5, 64'd120);
        push_op(16'h00F1, 64'd10, 64'd3628800); push_done();
        d0 = done_cnt;
        start_job(16'h0080, 16'h00F0, 8'd2);
        wait_done(d0, 400);
        check("two_mem0", mem[16'h00F0], 64'd120);
        check("two_mem1", mem[16'h00F1], 64'd3628800);

        // 16-bit address wrap on both lists
        push_op(16'hFFFF, 64'd4, 64'd24);
        push_op(16'h0000, 64'd6, 64'd720); push_done();
        d0 = done_cnt;
        start_job(16'hFFFF, 16'hFFFF, 8'd2);
        wait_done(d0, 400);
        check("wrap_mem_ffff", mem[16'hFFFF], 64'd24);
        check("wrap_mem_0000", mem[16'h0000], 64'd720);

        // grant stall: withheld 20 cycles, then dropped 5 cycles in WR_IEN
        push_op(16'h0091, 64'd5, 64'd120); push_done();
        d0 = done_cnt;
        hold = 1'b1;
        start_job(16'h0090, 16'h0091, 8'd1);
        repeat (20) begin
            @(negedge clk);
            check("stall_req_held", {63'd0, m_req}, 64'd1);
        end
        @(posedge clk); #1 hold = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (m_req && m_addr == 16'h7018) break;
            @(posedge clk); #1;
        end
        hold = 1'b1;
        a0 = m_addr;
        check("stall_at_ien", {48'd0, a0}, 64'h7018);
        repeat (5) begin
            @(negedge clk);
            check("stall_no_wr", {63'd0, m_wr}, 64'd0);
            check("stall_addr", {48'd0, m_addr}, {48'd0, a0});
            check("stall_dout", m_dout, 64'd1);
        end
        @(posedge clk); #1 hold = 1'b0;
        wait_done(d0, 400);
        check("stall_mem", mem[16'h0091], 64'd120);

        // count = 0
        push_done();
        d0 = done_cnt;
        start_job(16'h0070, 16'h0072, 8'd0);
        repeat (5) begin
            @(negedge clk);
            check("zero_no_req", {63'd0, m_req}, 64'd0);
        end
        wait_done(d0, 10);

        // spurious interrupt while reading the operand
        push_op(16'h00A1, 64'd5, 64'd120); push_done();
        d0 = done_cnt;
        start_job(16'h00A0, 16'h00A1, 8'd1);
        for (int k = 0; k < 50; k++) begin
            if (m_req && !m_wr && m_addr == 16'h00A0) break;
            @(posedge clk); #1;
        end
        irq_spur = 1'b1;
        @(posedge clk); #1 irq_spur = 1'b0;
        wait_done(d0, 400);
        check("spur_mem", mem[16'h00A1], 64'd120);

        // reset during WAIT_IRQ
        push_op(16'h00B1, 64'd5, 64'd120); push_done();
        d0 = done_cnt;
        start_job(16'h00B0, 16'h00B1, 8'd1);
        for (int k = 0; k < 100; k++) begin
            if (m_req && m_addr == 16'h7010) break;
            @(posedge clk); #1;
        end
        check("rst_in_wait", {48'd0, m_addr}, 64'h7010);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        check("midrst_pending", 64'(sbq.size()), 64'd4);
        sbq.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("midrst_quiet", {63'd0, m_req}, 64'd0);
        end
        check("midrst_no_done", 64'(done_cnt), 64'(d0));
        check("midrst_mem", mem[16'h00B1], 64'hDEAD);

        push_op(16'h00C1, 64'd5, 64'd120); push_done();
        d0 = done_cnt;
        start_job(16'h00C0, 16'h00C1, 8'd1);
        wait_done(d0, 200);
        check("postrst_mem", mem[16'h00C1], 64'd120);

        // count = 255
        for (int i = 0; i < 255; i++)
            push_op(16'h0400 + 16'(i), 64'(i % 4 + 1), tab[i % 4]);
        push_done();
        d0 = done_cnt;
        start_job(16'h0100, 16'h0400, 8'd255);
        wait_done(d0, 9000);
        check("max_first", mem[16'h0400], 64'd1);
        check("max_last", mem[16'h04FE], 64'd6);
        check("max_beyond", mem[16'h04FF], 64'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/facto_master.md
FACTO_MASTER -- requirements
Module: facto_master

Interface
REQ-001 The block SHALL have parameter CORE_BASE, default 16'h7000, meaning the factorial-core register base (opstart +0x00, opclear +0x08, opdone +0x10, intrEn +0x18, operand +0x20, result +0x30).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
 clk  in  1  rising-edge clock
 reset_n  in  1  asynchronous active-low reset
 start  in  1  one-cycle job start pulse
 src_base  in  16  memory word address of the first operand
 dst_base  in  16  memory word address of the first result
 count  in  8  number of operands in the job
 busy  out  1  job in progress
 done  out  1  one-cycle job-complete pulse
 m_req  out  1  bus request to arbiter
 m_grant  in  1  bus granted
 m_wr  out  1  1 = write, 0 = read
 m_addr  out  16  bus address
 m_dout  out  64  write data
 m_din  in  64  read data
 interrupt  in  1  factorial-core completion interrupt

Function
REQ-003 start SHALL be sampled only in IDLE; src_base, dst_base and count SHALL be latched on that edge, and start while busy SHALL be ignored.
REQ-004 start with count = 0 SHALL pulse done on the next cycle, with no m_req.
REQ-005 Otherwise busy SHALL rise on the cycle after start, and m_req SHALL be held at 1 from that cycle until the final memory write completes.
REQ-006 The FSM SHALL use the states IDLE, REQ, RD_OP, RD_OP_W, WR_OPND, WR_IEN, WR_STRT, WAIT_IRQ, RD_RES, RD_RES_W, WR_CLR1, WR_CLR0, WR_MEM, NEXT and DONE.
REQ-007 Each bus state SHALL last exactly one cycle while m_grant = 1.
REQ-008 While m_grant = 0, the FSM SHALL hold its state, drive m_wr = 0, and keep m_addr and m_dout unchanged.
REQ-009 Reads SHALL use one-cycle latency: RD_x drives the address with m_wr = 0, RD_x_W holds the address, and m_din is captured on the edge that ends RD_x_W.
REQ-010 The per-operand sequence for index i SHALL be:
 - read src_base+i
 - write CORE_BASE+0x20 = operand
 - write CORE_BASE+0x18 = 1
 - write CORE_BASE+0x00 = 1
 - in WAIT_IRQ, drive m_wr = 0 and m_addr = CORE_BASE+0x10, and wait for interrupt = 1
 - read CORE_BASE+0x30
 - write CORE_BASE+0x08 = 1, then CORE_BASE+0x08 = 0
 - write dst_base+i = result
REQ-011 Address arithmetic SHALL be 16-bit modulo: src_base+i and dst_base+i wrap from 16'hFFFF to 16'h0000.
REQ-012 The index counter SHALL be 8 bits and compare against the latched count; count = 255 SHALL process 255 operands.
REQ-013 NEXT SHALL increment i and return to RD_OP if i+1 < count, else go to DONE.
REQ-014 DONE SHALL drop m_req, pulse done for one cycle with busy = 0, and return to IDLE.
REQ-015 interrupt SHALL be ignored in every state except WAIT_IRQ.
REQ-016 In WAIT_IRQ, interrupt is acted on regardless of m_grant; the following RD_RES still waits for grant.
REQ-017 Operand data SHALL be passed to the core unmodified (full 64 bits), and results SHALL be written unmodified.

Reset
REQ-018 On reset_n = 0 the block SHALL asynchronously enter IDLE.
REQ-019 During reset, outputs SHALL be busy = 0, done = 0, m_req = 0, m_wr = 0, m_addr = 16'h0000 and m_dout = 64'h0, and the latched configuration and index SHALL be cleared.
REQ-020 Reset mid-job SHALL abort the job without a done pulse, and no further bus cycles SHALL be issued.
REQ-021 In IDLE, m_wr SHALL be 0 and m_addr and m_dout SHALL hold their reset values.

Verification
REQ-022 Single operand: mem[0x0070] = 5; start with src_base = 0x0070, dst_base = 0x0071, count = 1 -> writes 0x7020 = 5, 0x7018 = 1, 0x7000 = 1; after interrupt, writes 0x7008 = 1 then 0; mem[0x0071] = 120; one done pulse.
REQ-023 Two operands: mem[0x0080] = 5, mem[0x0081] = 10; dst_base = 0x00F0 -> mem[0x00F0] = 120, mem[0x00F1] = 3628800; exactly one done pulse, after the second write.
REQ-024 Grant stall: m_grant withheld for 20 cycles after m_req, then dropped for 5 cycles during WR_IEN -> no write while m_grant = 0; final result is unchanged.
REQ-025 count = 0 -> done on the next cycle; m_req never asserted; no bus traffic.
REQ-026 Assert reset_n = 0 during WAIT_IRQ -> all outputs reach reset values immediately and there is no done pulse; a following count = 1 job (operand 5) writes 120.
REQ-027 Spurious interrupt during RD_OP -> ignored; WAIT_IRQ still waits for a fresh interrupt before reading 0x7030.
